mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit producing HI/LO results for the multicycle CPU datapath. It replaces the separate fixed-width mult and div units with one shared engine. It supports signed and unsigned variants, a start/busy/done handshake, and divide-by-zero detection. The control FSM issues start and writes the HI/LO registers from the hi/lo outputs when done pulses.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_sign_fix.sv | 15 +
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and small op-decoding helpers.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate. Used as abs() on the operands
// (neg = signed op and MSB set) and as the sign correction on results.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Negate when requested; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    assign result = neg ? ({W{1'b0}} - value) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing HI/LO results.
// MULT/MULTU: radix-2 shift-add, DIV/DIVU: restoring shift-subtract,
// both on magnitudes with sign correction in a final FIX cycle.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave RUN as soon as
// the remaining multiplier bits are zero; FIX realigns the accumulator.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    mdu_state_e         state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   opnd;     // multiplicand magnitude, or divisor magnitude
    logic [WIDTH-1:0]   mplier;   // unconsumed multiplier bits, LSB first
    logic [2*WIDTH-1:0] acc;      // mult: partial product; div: {remainder, quotient}
    logic [CNT_W-1:0]   cnt;
    logic               neg_res;  // product / quotient must be negated
    logic               neg_rem;  // remainder must be negated (dividend sign)

    // Operand magnitudes for the signed variants.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = op_is_signed(op) & a[WIDTH-1];
    assign b_neg = op_is_signed(op) & b[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (.value(a), .neg(a_neg), .result(a_mag));
    mdu_sign_fix #(.W(WIDTH)) u_abs_b (.value(b), .neg(b_neg), .result(b_mag));

    // One shift-add step: add multiplicand to the upper half if the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits, recording the quotient bit.
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd};
    assign div_fits  = (div_trial >= {1'b0, opnd});
    assign div_next  = div_fits ? {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1}
                                : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    // RUN exit condition and the product alignment seen by FIX.
    logic               run_last;
    logic [2*WIDTH-1:0] prod_raw;

`ifdef MDU_EARLY_TERM_EN
    assign run_last = (cnt == '0) || (!op_is_div(op_r) && (mplier[WIDTH-1:1] == '0));
    // cnt holds the number of iterations skipped; the product still sits
    // that many places too high.
    assign prod_raw = acc >> cnt;
`else
    assign run_last = (cnt == '0);
    assign prod_raw = acc;
`endif

    // Sign correction of the finished results.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.value(prod_raw), .neg(neg_res), .result(prod_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_quot (.value(acc[WIDTH-1:0]), .neg(neg_res), .result(quot_fix));
    mdu_sign_fix #(.W(WIDTH)) u_fix_rem  (.value(acc[2*WIDTH-1:WIDTH]), .neg(neg_rem), .result(rem_fix));

    assign busy = (state != IDLE);

    // Control FSM and iterative datapath.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are cleared too, so an aborted
            // operation leaves no stale partial result behind.
            state    <= IDLE;
            op_r     <= 2'b00;
            opnd     <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op_is_div(op) && (b == '0)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            op_r    <= op;
                            opnd    <= op_is_div(op) ? b_mag : a_mag;
                            mplier  <= b_mag;
                            acc     <= op_is_div(op) ? {{WIDTH{1'b0}}, a_mag} : '0;
                            cnt     <= CNT_W'(WIDTH - 1);
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (op_is_div(op_r)) begin
                        acc <= div_next;
                    end else begin
                        acc    <= mul_next;
                        mplier <= mplier >> 1;
                    end
                    if (run_last) state <= FIX;
                    else          cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    if (op_is_div(op_r)) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH = 32): directed cases plus
// randomized operations, checked by a queue-based scoreboard against a
// plain-arithmetic reference model. Honors MDU_EARLY_TERM_EN for latency.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_zero;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural values.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output exp_t e);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        case (o)
            MDU_MULT: begin
                p = 64'(sx * sy);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MDU_DIV: begin
                if (y == '0) e.dz = 1'b1;
                else begin
                    q = sx / sy; r = sx % sy;
                    m_hi = r[31:0]; m_lo = q[31:0];
                end
            end
            default: begin
                if (y == '0) e.dz = 1'b1;
                else begin
                    m_hi = x % y; m_lo = x / y;
                end
            end
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Expected number of rising edges after the start edge until done is seen.
    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        logic [W-1:0] mag;
        int           k;
        if (o[1] && y == '0) return 0;
`ifdef MDU_EARLY_TERM_EN
        if (!o[1]) begin
            mag = (o == MDU_MULT && y[W-1]) ? -y : y;
            k = 1;
            for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
            return k + 1;
        end
`endif
        return W + 1;
    endfunction

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        if (prev_done) begin
            check("done_one_cycle", done, 1'b0);
            check("div_zero_clear", div_zero, 1'b0);
        end
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("div_zero", div_zero, mon_e.dz);
            end
        end
        prev_done = done;
    end

    // Issue one operation; optionally poke start at RUN step poke_at, or
    // assert reset at step abort_at.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int poke_at, input int abort_at);
        exp_t e;
        int   lat, elat;
        bit   busy_ok, fin;
        model(o, x, y, e);
        elat = exp_lat(o, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        lat = 0; busy_ok = 1'b1; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (lat == poke_at) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom | 1;
            end else begin
                start = 1'b0;
                if (lat == 0) begin op = 2'($urandom); a = $urandom; b = $urandom; end
            end
            if (lat == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_hi", hi, '0);
                check("abort_lo", lo, '0);
                check("abort_busy", busy, 1'b0);
                sb.delete();
                m_hi = '0; m_lo = '0;
                start = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("abort_no_done", done, 1'b0);
                end
                reset = 1'b1;
                return;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) fin = 1'b1;
            else if (lat > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL done_timeout: got no done after %0d edges, expected %0d", lat, elat);
                sb.delete();
                return;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        check("latency", 64'(lat), 64'(elat));
        check("busy_while_active", busy_ok, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        #1;
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_div_zero", div_zero, 1'b0);
        #12 reset = 1'b1;

        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd7,        -1, -1);
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,        -1, -1);
        run_op(MDU_DIVU,  32'd7,         32'd2,        -1, -1);
        run_op(MDU_DIV,   32'd123,       32'd0,        -1, -1);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(MDU_DIV,   32'd100,       32'hFFFF_FFF9, -1, -1);
        run_op(MDU_MULT,  32'h1234_5678, 32'h8765_4321, 10, -1);
        run_op(MDU_MULTU, 32'hDEAD_BEEF, 32'hCAFE_F00D, -1, 5);
        run_op(MDU_DIVU,  32'd9,         32'd0,        -1, -1);
        run_op(MDU_MULTU, 32'd5,         32'd1,        -1, -1);
        run_op(MDU_MULTU, 32'd5,         32'h8000_0000, -1, -1);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(MDU_DIVU,  32'hFFFF_FFFF, 32'd1,        -1, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, -1, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
